// File: rtl/serial_adder_if.sv
// Operand/result bundle for the bit-serial adder: requester drives master, adder implements slave.
interface serial_adder_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start, a, b, cin, sub,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, a, b, cin, sub,
    output busy, done, sum, cout, ovf
  );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial add/subtract: one full-adder stage and a carry flop, LSB first, WIDTH cycles per result.
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  serial_adder_if.slave bus
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               carry_q, carry_d;
  logic               sub_q, sub_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;

  logic               b_bit_c;
  logic               s_c;
  logic               co_c;

  // Single full-adder stage; B is inverted for subtract (carry preloaded with 1).
  always_comb begin
    b_bit_c = b_q[0] ^ sub_q;
    s_c     = a_q[0] ^ b_bit_c ^ carry_q;
    co_c    = (a_q[0] & b_bit_c) | (a_q[0] & carry_q) | (b_bit_c & carry_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      sub_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      sub_q   <= sub_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    carry_d = carry_q;
    sub_d   = sub_q;
    done_d  = 1'b0;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d = RUN;
          cnt_d   = '0;
          a_d     = bus.a;
          b_d     = bus.b;
          res_d   = '0;
          sub_d   = bus.sub;
          carry_d = bus.sub ? 1'b1 : bus.cin;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        res_d   = (res_q >> 1) | (WIDTH'(s_c) << (WIDTH - 1));
        carry_d = co_c;
        cnt_d   = cnt_q + CNT_W'(1);
        // On the MSB, carry_q is the carry into the MSB and co_c the carry out.
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = DONE;
          cnt_d   = '0;
          done_d  = 1'b1;
          sum_d   = res_d;
          cout_d  = co_c;
          ovf_d   = co_c ^ carry_q;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RUN);
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter: WIDTH, default 8, operand and result width in bits; the SHALL-supported range is 1 to 64.
REQ-002 clk  input  1  single clock; all state SHALL change on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 start  input  1  operation request, sampled on the rising edge of clk.
REQ-005 a  input  WIDTH  operand A, sampled when start is accepted.
REQ-006 b  input  WIDTH  operand B, sampled when start is accepted.
REQ-007 cin  input  1  carry-in, sampled when start is accepted, used only when sub=0.
REQ-008 sub  input  1  mode, sampled when start is accepted: 0 = add, 1 = subtract.
REQ-009 busy  output  1  high while an operation is in progress.
REQ-010 done  output  1  one-cycle pulse marking that the result outputs are updated.
REQ-011 sum  output  WIDTH  result.
REQ-012 cout  output  1  carry-out of the MSB.
REQ-013 ovf  output  1  two's-complement overflow.

Function
REQ-014 Datapath SHALL use exactly one 1-bit full-adder stage plus a carry flip-flop, processing one bit per cycle, LSB first.
REQ-015 State machine SHALL have states IDLE, RUN and DONE.
REQ-016 IDLE SHALL go to RUN when start=1; RUN SHALL go to DONE after WIDTH bit-cycles; DONE SHALL go to RUN when start=1 and to IDLE otherwise.
REQ-017 Start SHALL be accepted only in IDLE or DONE; start in RUN SHALL be ignored with no effect on the operation in progress.
REQ-018 On accept, the block SHALL latch a, b, cin and sub and set the carry flip-flop to (sub ? 1 : cin).
REQ-019 When sub=1, the B bit SHALL be inverted into the adder and cin SHALL be ignored.
REQ-020 Add mode SHALL produce {cout,sum} = a + b + cin, modulo 2^(WIDTH+1).
REQ-021 Subtract mode SHALL produce sum = a - b modulo 2^WIDTH, with cout = 1 when a >= b unsigned (no borrow).
REQ-022 ovf SHALL equal the carry into the MSB XOR the carry out of the MSB.
REQ-023 busy SHALL be high in every RUN cycle and low in IDLE and DONE.
REQ-024 Latency: start accepted at edge E implies done=1 in the cycle after edge E+WIDTH.
REQ-025 done SHALL be high only in DONE, for exactly one cycle per operation.
REQ-026 sum, cout and ovf SHALL update only on the edge that enters DONE.
REQ-027 sum, cout and ovf SHALL hold their values until the next DONE entry, including while a later operation is running.
REQ-028 Back-to-back operation: start=1 in the DONE cycle SHALL begin the next operation with no idle cycle, giving a throughput of one result per WIDTH+1 cycles.
REQ-029 WIDTH=1 SHALL behave as a registered full adder: cout is the carry and ovf = carry-in XOR cout.
REQ-030 Input changes on a, b, cin or sub after accept SHALL NOT affect the operation in progress.

Reset
REQ-031 rst_n=0 SHALL immediately force IDLE, busy=0, done=0, sum=0, cout=0, ovf=0, and clear the carry flip-flop, bit counter and operand registers.
REQ-032 Reset asserted mid-operation SHALL abort it with no done pulse and the outputs zeroed.
REQ-033 The first start accepted after rst_n rises SHALL behave as from IDLE.

Verification
REQ-034 WIDTH=8, add, a=8'hFF, b=8'h01, cin=0 -> busy for 8 cycles, then done, with sum=8'h00, cout=1, ovf=0.
REQ-035 WIDTH=8, add, a=8'h7F, b=8'h01, cin=0 -> sum=8'h80, cout=0, ovf=1.
REQ-036 WIDTH=8, sub, a=8'h05, b=8'h07, cin=1 -> sum=8'hFE, cout=0, ovf=0 (cin ignored).
REQ-037 WIDTH=8, start with a=8'h10, b=8'h20; at RUN cycle 3 pulse start with a=8'hAA -> single done with sum=8'h30; then start in the DONE cycle -> busy=1 on the next cycle.
REQ-038 WIDTH=8, rst_n=0 at RUN cycle 4 after a prior result of 8'h30 -> sum=0, busy=0, no done; a new start completes correctly.
REQ-039 WIDTH=1, all 8 combinations of a, b, cin, add mode -> {cout,sum} matches the full-adder truth table, done 1 cycle after accept each time.
